aes_avalon_ctrl: RTL and testbench

Avalon-MM slave that owns the software register file for the AES encryption core and sequences one encryption per software request. It snapshots the key and plaintext into the core, raises the core's Start, waits for its Done with a watchdog, captures the ciphertext and reports completion. It sits between the Avalon interconnect and the AES core's Start/Done handshake.

---
 rtl/aes_avalon_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_aes_avalon_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_avalon_ctrl.sv
// aes_avalon_ctrl
// Avalon-MM slave holding the software register file of the AES core. Each
// software start snapshots KEY/MSG_IN into the core, raises AES_START, waits
// for AES_DONE under a watchdog, captures the ciphertext and reports DONE.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   AVL_CS/READ/WRITE     Avalon-MM slave strobes (READ/WRITE qualified by CS)
//   AVL_ADDR              word address 0-15
//   AVL_BYTE_EN           per-byte write enables
//   AVL_WRITEDATA         write data
//   AVL_READDATA          combinational read data (0 when not reading)
//   AES_KEY, AES_MSG_IN   key/plaintext to the core, frozen for a whole run
//   AES_START             core start request
//   AES_DONE, AES_MSG_OUT core completion level and ciphertext
//   EXPORT_DATA           {MSG_OUT[127:112], MSG_OUT[15:0]} for a hex display
//
// Register map (words): 0-3 KEY, 4-7 MSG_IN, 8-11 MSG_OUT (RO),
// 12 STATUS {ERROR,BUSY} (RO), 13 CYCLES (RO), 14 START, 15 DONE (RO).
// Lower word numbers hold the more significant 32 bits.
module aes_avalon_ctrl #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         AVL_CS,
    input  logic         AVL_READ,
    input  logic         AVL_WRITE,
    input  logic [3:0]   AVL_ADDR,
    input  logic [3:0]   AVL_BYTE_EN,
    input  logic [31:0]  AVL_WRITEDATA,
    output logic [31:0]  AVL_READDATA,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG_IN,
    output logic         AES_START,
    input  logic         AES_DONE,
    input  logic [127:0] AES_MSG_OUT,
    output logic [31:0]  EXPORT_DATA
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_RUN, ST_CAPTURE, ST_HOLD, ST_FAULT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_key [0:3];
    logic [31:0]      r_msg [0:3];
    logic [127:0]     r_msg_out;
    logic [127:0]     r_aes_key;
    logic [127:0]     r_aes_msg;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cycles;
    logic             r_start;
    logic             r_done;
    logic             r_error;

    logic             w_wr;
    logic             w_busy;
    logic             w_wr_data_reg;
    logic             w_begin_run;
    logic             w_set_error;
    logic [CNT_W-1:0] w_cnt_inc;

    function automatic logic [31:0] f_byte_merge(input logic [31:0] old_val,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

    assign w_wr          = AVL_CS & AVL_WRITE;
    assign w_wr_data_reg = w_wr & ~AVL_ADDR[3];
    assign w_busy        = (r_state == ST_LOAD) || (r_state == ST_RUN) ||
                           (r_state == ST_CAPTURE) || (r_state == ST_HOLD);
    // Decoded straight from the state register so an asynchronous reset
    // drops the start request immediately.
    assign AES_START     = (r_state == ST_RUN) || (r_state == ST_CAPTURE) ||
                           (r_state == ST_HOLD);
    // Saturating increment: the watchdog never wraps past TIMEOUT.
    assign w_cnt_inc     = (r_cnt == CNT_W'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;

    assign AES_KEY     = r_aes_key;
    assign AES_MSG_IN  = r_aes_msg;
    assign EXPORT_DATA = {r_msg_out[127:112], r_msg_out[15:0]};

    always_comb begin
        w_next      = r_state;
        w_begin_run = 1'b0;
        w_set_error = 1'b0;
        case (r_state)
            // Every path back to IDLE requires START=0, so a START level of 1
            // seen here always comes from a fresh 0->1 software write.
            ST_IDLE: begin
                if (r_start) begin
                    w_next      = ST_LOAD;
                    w_begin_run = 1'b1;
                end
            end
            ST_LOAD: w_next = ST_RUN;
            // Priority: software abort, then Done, then watchdog expiry.
            // The watchdog fires on the edge where the count reaches TIMEOUT,
            // so AES_START stays high for exactly TIMEOUT cycles.
            ST_RUN: begin
                if (!r_start) begin
                    w_next      = ST_IDLE;
                    w_set_error = 1'b1;
                end else if (AES_DONE) begin
                    w_next = ST_CAPTURE;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    w_next      = ST_FAULT;
                    w_set_error = 1'b1;
                end
            end
            ST_CAPTURE: w_next = ST_HOLD;
            ST_HOLD: begin
                if (!r_start) w_next = ST_IDLE;
            end
            ST_FAULT: begin
                if (!r_start) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                r_key[i] <= '0;
                r_msg[i] <= '0;
            end
            r_msg_out <= '0;
            r_aes_key <= '0;
            r_aes_msg <= '0;
            r_cnt     <= '0;
            r_cycles  <= '0;
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_wr_data_reg && !w_busy) begin
                if (!AVL_ADDR[2])
                    r_key[AVL_ADDR[1:0]] <= f_byte_merge(r_key[AVL_ADDR[1:0]], AVL_WRITEDATA, AVL_BYTE_EN);
                else
                    r_msg[AVL_ADDR[1:0]] <= f_byte_merge(r_msg[AVL_ADDR[1:0]], AVL_WRITEDATA, AVL_BYTE_EN);
            end

            if (w_wr && (AVL_ADDR == 4'd14) && AVL_BYTE_EN[0])
                r_start <= AVL_WRITEDATA[0];

            if (r_state == ST_LOAD) begin
                r_aes_key <= {r_key[0], r_key[1], r_key[2], r_key[3]};
                r_aes_msg <= {r_msg[0], r_msg[1], r_msg[2], r_msg[3]};
                r_cnt     <= '0;
            end

            if (r_state == ST_RUN)
                r_cnt <= w_cnt_inc;

            if (w_begin_run) begin
                r_done   <= 1'b0;
                r_error  <= 1'b0;
                r_cycles <= '0;
            end

            // Key/plaintext writes while busy are dropped but flagged.
            if (w_set_error || (w_wr_data_reg && w_busy))
                r_error <= 1'b1;

            if (r_state == ST_CAPTURE) begin
                r_msg_out <= AES_MSG_OUT;
                r_cycles  <= r_cnt;
                r_done    <= 1'b1;
            end
        end
    end

    always_comb begin
        AVL_READDATA = '0;
        if (AVL_CS && AVL_READ) begin
            case (AVL_ADDR)
                4'd0, 4'd1, 4'd2, 4'd3: AVL_READDATA = r_key[AVL_ADDR[1:0]];
                4'd4, 4'd5, 4'd6, 4'd7: AVL_READDATA = r_msg[AVL_ADDR[1:0]];
                4'd8:  AVL_READDATA = r_msg_out[127:96];
                4'd9:  AVL_READDATA = r_msg_out[95:64];
                4'd10: AVL_READDATA = r_msg_out[63:32];
                4'd11: AVL_READDATA = r_msg_out[31:0];
                4'd12: AVL_READDATA = {30'b0, r_error, w_busy};
                4'd13: AVL_READDATA = 32'(r_cycles);
                4'd14: AVL_READDATA = {31'b0, r_start};
                default: AVL_READDATA = {31'b0, r_done};
            endcase
        end
    end

endmodule

// File: tb/tb_aes_avalon_ctrl.sv
module tb_aes_avalon_ctrl;

    localparam int TO = 16;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         AVL_CS = 1'b0;
    logic         AVL_READ = 1'b0;
    logic         AVL_WRITE = 1'b0;
    logic [3:0]   AVL_ADDR = '0;
    logic [3:0]   AVL_BYTE_EN = '0;
    logic [31:0]  AVL_WRITEDATA = '0;
    logic [31:0]  AVL_READDATA;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_IN;
    logic         AES_START;
    logic         AES_DONE = 1'b0;
    logic [127:0] AES_MSG_OUT = '0;
    logic [31:0]  EXPORT_DATA;

    aes_avalon_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .AES_KEY(AES_KEY), .AES_MSG_IN(AES_MSG_IN), .AES_START(AES_START),
        .AES_DONE(AES_DONE), .AES_MSG_OUT(AES_MSG_OUT), .EXPORT_DATA(EXPORT_DATA)
    );

    always #5 Clk = ~Clk;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // Stand-in for the AES core: known answer for the FIPS vector, otherwise
    // an arbitrary but key/plaintext-dependent mix.
    function automatic logic [127:0] aes_stub(input logic [127:0] k, input logic [127:0] m);
        if (k == FIPS_KEY && m == FIPS_PT) return FIPS_CT;
        return k ^ {m[63:0], m[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    int core_lat = 4;
    bit core_never = 1'b0;
    int core_c = 0;

    always @(posedge Clk) begin
        if (!AES_START) begin
            core_c   <= 0;
            AES_DONE <= 1'b0;
        end else begin
            core_c <= core_c + 1;
            if (!core_never && (core_c + 1 >= core_lat)) begin
                AES_DONE    <= 1'b1;
                AES_MSG_OUT <= aes_stub(AES_KEY, AES_MSG_IN);
            end
        end
    end

    // Software-visible reference model.
    logic [31:0]  m_key [4];
    logic [31:0]  m_msg [4];
    logic [127:0] m_out, snap_key, snap_msg;
    logic         m_start, m_done, m_err, m_busy;
    int           m_cycles;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_key[i] = '0;
            m_msg[i] = '0;
        end
        m_out = '0; m_start = 0; m_done = 0; m_err = 0; m_busy = 0; m_cycles = 0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        case (a)
            4'd0, 4'd1, 4'd2, 4'd3: return m_key[a[1:0]];
            4'd4, 4'd5, 4'd6, 4'd7: return m_msg[a[1:0]];
            4'd8:  return m_out[127:96];
            4'd9:  return m_out[95:64];
            4'd10: return m_out[63:32];
            4'd11: return m_out[31:0];
            4'd12: return {30'b0, m_err, m_busy};
            4'd13: return m_cycles;
            4'd14: return {31'b0, m_start};
            default: return {31'b0, m_done};
        endcase
    endfunction

    // Scoreboard: 0 = AVL_READDATA, 1 = AES_START, 2 = EXPORT_DATA.
    logic [31:0] exp_q [$];
    int          sel_q [$];
    string       name_q [$];
    logic        chk_vld = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] e);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: actual %08h required %08h", nm, act, e);
        end
    endfunction

    logic [31:0] mon_e, mon_act;
    int          mon_s;
    string       mon_nm;

    always @(negedge Clk) begin
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL scoreboard_underflow: actual empty required entry");
            end else begin
                mon_e  = exp_q.pop_front();
                mon_s  = sel_q.pop_front();
                mon_nm = name_q.pop_front();
                case (mon_s)
                    0:       mon_act = AVL_READDATA;
                    1:       mon_act = {31'b0, AES_START};
                    default: mon_act = EXPORT_DATA;
                endcase
                cmp(mon_nm, mon_act, mon_e);
            end
        end
    end

    task automatic expect_out(input int sel, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(nm);
        chk_vld = 1'b1;
        @(posedge Clk); #1;
        chk_vld = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
        expect_out(0, e, nm);
        AVL_CS = 0; AVL_READ = 0;
    endtask

    task automatic chk_start(input logic v, input string nm);
        expect_out(1, {31'b0, v}, nm);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        @(posedge Clk); #1;
        AVL_CS = 0; AVL_WRITE = 0;
        if (a < 8) begin
            if (m_busy) m_err = 1;
            else if (a < 4) m_key[a[1:0]] = merge(m_key[a[1:0]], d, be);
            else m_msg[a[1:0]] = merge(m_msg[a[1:0]], d, be);
        end
        if (a == 4'd14 && be[0]) m_start = d[0];
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic start_run(input int lat, input bit never);
        core_lat = lat; core_never = never;
        wr(4'd14, 32'h1, 4'h1);
        snap_key = {m_key[0], m_key[1], m_key[2], m_key[3]};
        snap_msg = {m_msg[0], m_msg[1], m_msg[2], m_msg[3]};
        m_done = 0; m_err = 0; m_cycles = 0; m_busy = 1;
        chk_start(1'b0, "start_lat_c0");
        chk_start(1'b0, "start_lat_c1");
        chk_start(1'b1, "start_lat_c2");
        rd(4'd15, exp_rd(4'd15), "done_cleared_on_start");
        rd(4'd12, exp_rd(4'd12), "status_busy_in_run");
    endtask

    task automatic finish_run(input int lat);
        idle(lat + 4);
        m_out = aes_stub(snap_key, snap_msg);
        m_done = 1;
        m_cycles = lat + 1;
        for (int i = 8; i < 12; i++) rd(4'(i), exp_rd(4'(i)), "msg_out_word");
        rd(4'd13, exp_rd(4'd13), "cycles");
        rd(4'd15, 32'h1, "done_set");
        rd(4'd12, exp_rd(4'd12), "status_hold");
        expect_out(2, {m_out[127:112], m_out[15:0]}, "export_data");
        chk_start(1'b1, "start_held_in_hold");
    endtask

    task automatic stop_hold();
        wr(4'd14, 32'h0, 4'h1);
        idle(1);
        m_busy = 0;
        chk_start(1'b0, "start_drop_after_clear");
        rd(4'd12, exp_rd(4'd12), "status_after_clear");
        rd(4'd15, exp_rd(4'd15), "done_kept_after_clear");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual time limit hit required completion");
        $fatal(1, "simulation time limit");
    end

    int lat, rise_idx, hi_cnt;
    logic [3:0] ra;

    initial begin
        model_reset();
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Reset state
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, "reset_reg");
        chk_start(1'b0, "reset_start");
        expect_out(2, 32'h0, "reset_export");

        // Byte enables
        wr(4'd0, 32'hAABBCCDD, 4'b0101);
        rd(4'd0, 32'h00BB00DD, "byte_en_word0");

        // Random register traffic (START excluded)
        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom_range(0, 15));
            if (ra == 4'd14) ra = 4'd13;
            wr(ra, $urandom, 4'($urandom_range(0, 15)));
            rd(ra, exp_rd(ra), "random_rw");
        end

        // FIPS-197 vector
        wr(4'd0, 32'h00010203, 4'hF); wr(4'd1, 32'h04050607, 4'hF);
        wr(4'd2, 32'h08090a0b, 4'hF); wr(4'd3, 32'h0c0d0e0f, 4'hF);
        wr(4'd4, 32'h00112233, 4'hF); wr(4'd5, 32'h44556677, 4'hF);
        wr(4'd6, 32'h8899aabb, 4'hF); wr(4'd7, 32'hccddeeff, 4'hF);
        lat = $urandom_range(1, 8);
        start_run(lat, 1'b0);
        finish_run(lat);
        rd(4'd8,  32'h69c4e0d8, "fips_w8");
        rd(4'd9,  32'h6a7b0430, "fips_w9");
        rd(4'd10, 32'hd8cdb780, "fips_w10");
        rd(4'd11, 32'h70b4c55a, "fips_w11");
        expect_out(2, 32'h69c4c55a, "fips_export");

        // START left at 1 does not retrigger
        wr(4'd14, 32'h1, 4'h1);
        idle(4);
        chk_start(1'b1, "no_retrigger_start");
        rd(4'd13, exp_rd(4'd13), "no_retrigger_cycles");
        stop_hold();

        // Second run with random data
        for (int i = 0; i < 8; i++) wr(4'(i), $urandom, 4'hF);
        lat = $urandom_range(1, 10);
        start_run(lat, 1'b0);
        finish_run(lat);
        stop_hold();

        // Plaintext write while busy is dropped and flags ERROR
        start_run(8, 1'b0);
        wr(4'd5, $urandom, 4'hF);
        rd(4'd5, exp_rd(4'd5), "write_while_busy_ignored");
        finish_run(8);
        stop_hold();

        // Software abort during RUN
        start_run(12, 1'b0);
        idle(2);
        wr(4'd14, 32'h0, 4'h1);
        idle(1);
        m_busy = 0; m_err = 1;
        chk_start(1'b0, "abort_start_low");
        rd(4'd12, exp_rd(4'd12), "abort_status");
        rd(4'd8, exp_rd(4'd8), "abort_msg_out_kept");
        rd(4'd15, exp_rd(4'd15), "abort_done");

        // Watchdog: core never answers
        core_never = 1'b1;
        wr(4'd14, 32'h1, 4'h1);
        m_done = 0; m_err = 0; m_cycles = 0;
        rise_idx = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (AES_START) begin
                rise_idx = i;
                break;
            end
        end
        cmp("timeout_rise_latency", rise_idx, 2);
        hi_cnt = (rise_idx >= 0) ? 1 : 0;
        if (rise_idx >= 0) begin
            for (int i = 0; i < 100; i++) begin
                @(negedge Clk);
                if (!AES_START) break;
                hi_cnt++;
            end
        end
        cmp("timeout_high_cycles", hi_cnt, TO);
        @(posedge Clk); #1;
        m_err = 1; m_busy = 0;
        rd(4'd12, 32'h2, "timeout_status");
        rd(4'd15, 32'h0, "timeout_done");
        rd(4'd13, exp_rd(4'd13), "timeout_cycles");
        wr(4'd14, 32'h0, 4'h1);
        idle(1);
        rd(4'd12, exp_rd(4'd12), "fault_to_idle_status");

        // Reset mid-run
        start_run(30, 1'b1);
        idle(2);
        chk_start(1'b1, "pre_reset_run");
        Reset_n = 1'b0;
        model_reset();
        chk_start(1'b0, "reset_mid_run_start");
        rd(4'd12, 32'h0, "reset_mid_run_status");
        rd(4'd15, 32'h0, "reset_mid_run_done");
        rd(4'd0, 32'h0, "reset_mid_run_key");
        expect_out(2, 32'h0, "reset_mid_run_export");
        Reset_n = 1'b1;
        idle(2);
        chk_start(1'b0, "post_reset_idle");
        rd(4'd14, 32'h0, "post_reset_start_reg");

        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_leftover: actual %0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
